// File: rtl/rv_plic_pkg.sv
// Shared sizing helpers and ID decode for the PLIC target path.
package rv_plic_pkg;

  localparam int PRIOW_DEF = 3;

  // ID width: IDs run 0..n, 0 meaning "no interrupt".
  function automatic int src_w(input int n);
    return $clog2(n + 1);
  endfunction

  // One bit of onehot(id): source index src carries ID src+1.
  function automatic logic onehot_bit(input logic [31:0] id, input int unsigned src);
    return id == (src + 32'd1);
  endfunction

endpackage

// File: rtl/rv_plic_prio_max.sv
// Combinational binary compare tree: highest priority wins, lowest ID on ties.
module rv_plic_prio_max
  import rv_plic_pkg::*;
#(
  parameter int N     = 32,
  parameter int PRIOW = PRIOW_DEF,
  localparam int SRCW = src_w(N)
) (
  input  logic [N-1:0]       i_valid,
  input  logic [N*PRIOW-1:0] i_prio,
  output logic [SRCW-1:0]    o_id,
  output logic               o_valid
);

  localparam int LVL    = $clog2(N);
  localparam int LEAVES = 1 << LVL;

  // Heap-ordered nodes: node n has children 2n and 2n+1, leaves at LEAVES..2*LEAVES-1,
  // so the left child always holds the lower IDs.
  logic [2*LEAVES-1:1]            w_v;
  logic [2*LEAVES-1:1][PRIOW-1:0] w_p;
  logic [2*LEAVES-1:1][SRCW-1:0]  w_id;

  for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
    if (g < N) begin : g_real
      assign w_v[LEAVES+g]  = i_valid[g];
      assign w_p[LEAVES+g]  = i_prio[g*PRIOW +: PRIOW];
      assign w_id[LEAVES+g] = SRCW'(g + 1);
    end else begin : g_pad
      assign w_v[LEAVES+g]  = 1'b0;
      assign w_p[LEAVES+g]  = '0;
      assign w_id[LEAVES+g] = '0;
    end
  end

  for (genvar g = 1; g < LEAVES; g++) begin : g_node
    logic w_right;
    // Right wins only on strictly greater priority, keeping the lower ID on ties.
    assign w_right = w_v[2*g+1] & (~w_v[2*g] | (w_p[2*g+1] > w_p[2*g]));
    assign w_v[g]  = w_v[2*g] | w_v[2*g+1];
    assign w_p[g]  = w_right ? w_p[2*g+1]  : w_p[2*g];
    assign w_id[g] = w_right ? w_id[2*g+1] : w_id[2*g];
  end

  assign o_valid = w_v[1];
  assign o_id    = w_v[1] ? w_id[1] : '0;

endmodule

// File: rtl/rv_plic_target_arbiter.sv
// Per-target PLIC arbiter: registered winner selection plus claim/complete one-hot decode.
module rv_plic_target_arbiter
  import rv_plic_pkg::*;
#(
  parameter int N_SOURCE = 32,
  parameter int PRIOW    = PRIOW_DEF,
  localparam int SRCW    = src_w(N_SOURCE)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_SOURCE-1:0]       ip_i,
  input  logic [N_SOURCE-1:0]       ie_i,
  input  logic [N_SOURCE*PRIOW-1:0] prio_i,
  input  logic [PRIOW-1:0]          threshold_i,
  input  logic                      claim_re_i,
  input  logic                      complete_we_i,
  input  logic [SRCW-1:0]           complete_id_i,
  output logic                      irq_o,
  output logic [SRCW-1:0]           irq_id_o,
  output logic [N_SOURCE-1:0]       claim_o,
  output logic [N_SOURCE-1:0]       complete_o
);

  logic [N_SOURCE-1:0] w_cand;
  logic [SRCW-1:0]     w_id;
  logic                w_valid;
  logic                w_claim_hit;
  logic                r_irq;
  logic [SRCW-1:0]     r_id;
  logic                r_mask;

  // Priority 0 can never beat an unsigned threshold, so it never becomes a candidate.
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_cand
    assign w_cand[i] = ip_i[i] & ie_i[i] & (prio_i[i*PRIOW +: PRIOW] > threshold_i);
  end

  rv_plic_prio_max #(
    .N     (N_SOURCE),
    .PRIOW (PRIOW)
  ) u_max (
    .i_valid (w_cand),
    .i_prio  (prio_i),
    .o_id    (w_id),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq  <= 1'b0;
      r_id   <= '0;
      r_mask <= 1'b0;
    end else begin
      r_irq  <= w_valid;
      r_id   <= w_id;
      r_mask <= w_claim_hit;
    end
  end

  // The cycle after a claim still holds the pre-clear selection; hide it.
  assign irq_o       = r_irq & ~r_mask;
  assign irq_id_o    = r_mask ? '0 : r_id;
  assign w_claim_hit = claim_re_i & irq_o;

  always_comb begin
    claim_o    = '0;
    complete_o = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      claim_o[i]    = rst_ni & w_claim_hit & onehot_bit(32'(irq_id_o), i);
      complete_o[i] = rst_ni & complete_we_i & onehot_bit(32'(complete_id_i), i);
    end
  end

endmodule

// File: tb/tb_rv_plic_target_arbiter.sv
// Scoreboard bench for rv_plic_target_arbiter: expected irq/id pushed at drive, popped after the edge.
module tb_rv_plic_target_arbiter;

  localparam int N  = 32;
  localparam int P  = 3;
  localparam int SW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    ip, ie;
  logic [N*P-1:0]  prio;
  logic [P-1:0]    thr;
  logic            claim_re, cpl_we;
  logic [SW-1:0]   cpl_id;
  logic            irq;
  logic [SW-1:0]   irq_id;
  logic [N-1:0]    claim, cpl;

  logic [SW:0]     exp_q[$];
  int              n_vec = 0;
  int              n_err = 0;

  rv_plic_target_arbiter #(.N_SOURCE(N), .PRIOW(P)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ip_i          (ip),
    .ie_i          (ie),
    .prio_i        (prio),
    .threshold_i   (thr),
    .claim_re_i    (claim_re),
    .complete_we_i (cpl_we),
    .complete_id_i (cpl_id),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .claim_o       (claim),
    .complete_o    (cpl)
  );

  always #5 clk = ~clk;

  // Straight linear scan: strictly-greater keeps the lowest ID on ties.
  function automatic logic [SW:0] ref_arb(input logic [N-1:0] p, input logic [N-1:0] e,
                                          input logic [N*P-1:0] pr, input logic [P-1:0] t);
    int best = 0;
    int bp   = 0;
    for (int i = 0; i < N; i++) begin
      int v = int'(pr[i*P +: P]);
      if (p[i] && e[i] && v > int'(t) && v > bp) begin
        bp   = v;
        best = i + 1;
      end
    end
    return {best != 0, SW'(best)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ip = '0; ie = '0; prio = '0; thr = '0;
    claim_re = 1'b0; cpl_we = 1'b0; cpl_id = '0;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [SW:0] e;
    rst_n = 1'b0; ip = '1; ie = '1; thr = '0;
    for (int i = 0; i < N; i++) prio[i*P +: P] = 3'd1;
    claim_re = 1'b1; cpl_we = 1'b1; cpl_id = 6'd5;
    repeat (3) begin
      step();
      n_vec++;
      if ({irq, irq_id, claim, cpl} !== '0) begin
        n_err++;
        $display("FAIL reset_hold: irq=%0b id=%0d claim=%h cpl=%h, want all 0", irq, irq_id, claim, cpl);
      end
    end
    rst_n = 1'b1; claim_re = 1'b0; cpl_we = 1'b0;
    exp_q.push_back({1'b1, 6'd1});
    step();
    e = exp_q.pop_front();
    n_vec++;
    if ({irq, irq_id} !== e) begin
      n_err++;
      $display("FAIL reset_release: irq=%0b id=%0d, want irq=%0b id=%0d", irq, irq_id, e[SW], e[SW-1:0]);
    end
  endtask

  task automatic test_prio_tie();
    logic [SW:0] e;
    int thr_t[3] = '{0, 5, 4};
    int id_t[3]  = '{8, 0, 8};
    idle();
    ie = '1;
    ip = (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 9);
    prio[3*P +: P] = 3'd2;
    prio[7*P +: P] = 3'd5;
    prio[9*P +: P] = 3'd5;
    for (int k = 0; k < 3; k++) begin
      thr = P'(thr_t[k]);
      exp_q.push_back({id_t[k] != 0, SW'(id_t[k])});
      step();
      e = exp_q.pop_front();
      n_vec++;
      if ({irq, irq_id} !== e) begin
        n_err++;
        $display("FAIL prio_tie thr=%0d: irq=%0b id=%0d, want irq=%0b id=%0d", thr, irq, irq_id, e[SW], e[SW-1:0]);
      end
    end
  endtask

  task automatic test_enable_prio0();
    logic [SW:0] e;
    idle();
    ip = 32'd1 << 4;
    for (int pass = 0; pass < 2; pass++) begin
      ie = '1;
      if (pass == 0) prio[4*P +: P] = 3'd0;
      else begin
        prio[4*P +: P] = 3'd3;
        ie[4] = 1'b0;
      end
      for (int t = 0; t < 8; t++) begin
        thr = P'(t);
        exp_q.push_back('0);
        step();
        e = exp_q.pop_front();
        n_vec++;
        if ({irq, irq_id} !== e) begin
          n_err++;
          $display("FAIL en_prio0 pass=%0d thr=%0d: irq=%0b id=%0d, want 0", pass, t, irq, irq_id);
        end
      end
    end
    ie[4] = 1'b1; prio[4*P +: P] = 3'd1; thr = '0;
    exp_q.push_back({1'b1, 6'd5});
    step();
    e = exp_q.pop_front();
    n_vec++;
    if ({irq, irq_id} !== e) begin
      n_err++;
      $display("FAIL en_prio0_win: irq=%0b id=%0d, want irq=1 id=5", irq, irq_id);
    end
  endtask

  task automatic test_claim();
    logic [SW:0]  e;
    logic [N-1:0] gw;
    idle();
    ie = '1;
    ip = (32'd1 << 2) | (32'd1 << 6);
    prio[2*P +: P] = 3'd3;
    prio[6*P +: P] = 3'd1;
    exp_q.push_back({1'b1, 6'd3});
    step();
    e = exp_q.pop_front();
    n_vec++;
    if ({irq, irq_id} !== e) begin
      n_err++;
      $display("FAIL claim_setup: irq=%0b id=%0d, want irq=1 id=3", irq, irq_id);
    end
    // Cycle T: claim together with a complete of the same ID.
    claim_re = 1'b1; cpl_we = 1'b1; cpl_id = 6'd3;
    #1;
    n_vec++;
    if (claim !== 32'h4) begin
      n_err++;
      $display("FAIL claim_T: claim=%h, want 00000004", claim);
    end
    n_vec++;
    if (cpl !== 32'h4) begin
      n_err++;
      $display("FAIL claim_cpl_same: cpl=%h, want 00000004", cpl);
    end
    gw = claim;
    step();
    ip = ip & ~gw;
    cpl_we = 1'b0;
    #1;
    n_vec++;
    if ({irq, irq_id, claim} !== '0) begin
      n_err++;
      $display("FAIL claim_T1: irq=%0b id=%0d claim=%h, want all 0", irq, irq_id, claim);
    end
    claim_re = 1'b0;
    exp_q.push_back({1'b1, 6'd7});
    step();
    e = exp_q.pop_front();
    n_vec++;
    if ({irq, irq_id} !== e) begin
      n_err++;
      $display("FAIL claim_T2: irq=%0b id=%0d, want irq=1 id=7", irq, irq_id);
    end
  endtask

  task automatic test_complete();
    int          id_t[6]  = '{6, 0, 33, 1, 32, 63};
    logic [31:0] exp_t[6] = '{32'h20, 32'h0, 32'h0, 32'h1, 32'h8000_0000, 32'h0};
    idle();
    for (int k = 0; k < 6; k++) begin
      cpl_we = 1'b1; cpl_id = SW'(id_t[k]);
      #1;
      n_vec++;
      if (cpl !== exp_t[k]) begin
        n_err++;
        $display("FAIL complete id=%0d: cpl=%h, want %h", id_t[k], cpl, exp_t[k]);
      end
      step();
    end
    cpl_we = 1'b0; cpl_id = 6'd6;
    #1;
    n_vec++;
    if (cpl !== '0) begin
      n_err++;
      $display("FAIL complete_idle: cpl=%h, want 0", cpl);
    end
  endtask

  task automatic test_reset_mid_claim();
    logic [SW:0]  e;
    logic [N-1:0] gw;
    idle();
    ie = '1;
    ip = (32'd1 << 2) | (32'd1 << 6);
    prio[2*P +: P] = 3'd3;
    prio[6*P +: P] = 3'd1;
    step();
    claim_re = 1'b1;
    #1;
    n_vec++;
    if (claim !== 32'h4) begin
      n_err++;
      $display("FAIL rmc_claim: claim=%h, want 00000004", claim);
    end
    gw = claim;
    step();
    ip = ip & ~gw;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({irq, irq_id, claim} !== '0) begin
        n_err++;
        $display("FAIL rmc_in_reset k=%0d: irq=%0b id=%0d claim=%h, want 0", k, irq, irq_id, claim);
      end
      step();
    end
    rst_n = 1'b1; claim_re = 1'b0;
    #1;
    n_vec++;
    if ({irq, irq_id, claim} !== '0) begin
      n_err++;
      $display("FAIL rmc_release: irq=%0b id=%0d claim=%h, want 0", irq, irq_id, claim);
    end
    exp_q.push_back({1'b1, 6'd7});
    step();
    e = exp_q.pop_front();
    n_vec++;
    if ({irq, irq_id} !== e || claim !== '0) begin
      n_err++;
      $display("FAIL rmc_resume: irq=%0b id=%0d claim=%h, want irq=1 id=7 claim=0", irq, irq_id, claim);
    end
  endtask

  task automatic test_back_to_back();
    logic [SW:0] e;
    idle();
    exp_q.push_back('0);
    for (int k = 0; k < 300; k++) begin
      ip   = $urandom() | $urandom();
      ie   = $urandom() | $urandom();
      prio = {$urandom(), $urandom(), $urandom()};
      thr  = P'($urandom_range(0, 7));
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({irq, irq_id} !== e || (irq !== (irq_id != 0))) begin
        n_err++;
        $display("FAIL b2b k=%0d: irq=%0b id=%0d, want irq=%0b id=%0d", k, irq, irq_id, e[SW], e[SW-1:0]);
      end
      exp_q.push_back(ref_arb(ip, ie, prio, thr));
      step();
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({irq, irq_id} !== e) begin
      n_err++;
      $display("FAIL b2b_last: irq=%0b id=%0d, want irq=%0b id=%0d", irq, irq_id, e[SW], e[SW-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_prio_tie();
    test_enable_prio0();
    test_claim();
    test_complete();
    test_reset_mid_claim();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rv_plic_target_arbiter.md
Name: rv_plic_target_arbiter

Overview:
Per-target stage directly downstream of the PLIC gateway. It consumes the gateway's pending vector and selects the highest-priority enabled pending source above the target threshold. It drives the target interrupt line and the claim ID, and converts claim-read and complete-write strobes from the register interface into the per-source claim/complete one-hot vectors that feed back into the gateway. One instance per hart context.

Parameters:
N_SOURCE, 32, number of interrupt sources; source index i has ID i+1, and ID 0 means "no interrupt"
PRIOW, 3, priority field width; priority 0 means never interrupt
SRCW, $clog2(N_SOURCE+1), ID width (derived localparam, not overridable)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
ip_i  input  N_SOURCE  pending vector from the gateway
ie_i  input  N_SOURCE  per-source enable for this target
prio_i  input  N_SOURCE*PRIOW  packed priorities; source i occupies bits [i*PRIOW +: PRIOW]
threshold_i  input  PRIOW  target threshold
claim_re_i  input  1  single-cycle strobe: claim register read
complete_we_i  input  1  single-cycle strobe: complete register write
complete_id_i  input  SRCW  ID written to the complete register
irq_o  output  1  target interrupt request (registered)
irq_id_o  output  SRCW  current winning ID, readable as the claim value (registered)
claim_o  output  N_SOURCE  one-hot claim to the gateway (combinational)
complete_o  output  N_SOURCE  one-hot complete to the gateway (combinational)

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low. Reset drives irq_o=0, irq_id_o=0 and clears the mask flop. claim_o and complete_o are 0 while reset is asserted.
- Candidate: source i is a candidate when ip_i[i] & ie_i[i] & (prio_i[i] > threshold_i), using an unsigned compare. A source with priority 0 can never win, including when threshold is 0.
- Selection: the maximum priority among candidates wins. On equal priority, the lowest ID wins.
  - Implemented as a combinational binary compare tree.
  - No candidate gives id=0, irq=0.
- Latency: the selection is registered. A change on ip_i, ie_i, prio_i or threshold_i is visible on irq_o/irq_id_o one cycle later.
- Invariant: irq_o==1 exactly when irq_id_o!=0.
- Claim, cycle T:
  - claim_o = onehot(irq_id_o) gated by claim_re_i. If irq_id_o==0, claim_o=0 and the read returns 0.
  - The gateway clears ip at the end of T, so the registered selection would present a stale ID in T+1. A mask flop set by claim_re_i therefore forces irq_o=0 and irq_id_o=0 for cycle T+1; fresh arbitration is visible from T+2.
  - claim_re_i arriving in the masked cycle sees id 0 and produces no claim.
- Complete:
  - complete_o = onehot(complete_id_i) when complete_we_i=1 and 1<=complete_id_i<=N_SOURCE.
  - IDs 0 or >N_SOURCE are silently ignored (all zeros).
  - Completion is not checked against prior claims; gating by ie_i is not applied here.
- Simultaneous claim_re_i and complete_we_i: both vectors are driven independently, even for the same ID.
- Reset mid-operation: the mask is cleared and outputs go to 0 immediately (asynchronous). The first valid arbitration appears on the first edge after release.

Decomposition:
- rv_plic_pkg: PRIOW default, the src_id_t width function, and the onehot-from-ID helper function.
- One sub-module, rv_plic_prio_max: a parameterised max/argmin-ID compare tree (inputs are a valid vector and packed priorities; outputs are the winner ID and a valid flag). It is purely combinational; the arbiter registers its outputs.

Test Plan:
- Reset: hold rst_ni=0 with ip_i=all-ones and ie_i=all-ones → irq_o=0, irq_id_o=0, claim_o=0 throughout; after release, priorities all 1 and threshold 0 → irq_id_o=1 one cycle later.
- Priority/tie: ip bits 3, 7 and 9 set, prio 2, 5 and 5, threshold 0 → irq_id_o=8 (lowest ID among prio 5); then raise threshold to 5 → irq_o=0 and id=0 next cycle.
- Enable/priority 0: source 4 pending with prio 0 or ie=0 → irq_o stays 0 for all thresholds; set prio=1 and ie=1 → id=5 after one cycle.
- Claim handshake, with the gateway model attached:
  - Setup: sources 2 (prio 3) and 6 (prio 1) pending.
  - Claim in T → claim_o=0x4; irq_o=0 in T+1; irq_id_o=7 in T+2.
  - A second claim strobe in T+1 → claim_o=0.
- Complete decode: complete_id 6 → complete_o=0x20 for one cycle; complete_id 0 and complete_id 33 (N_SOURCE=32) → complete_o=0.
- Reset mid-claim: assert rst_ni low in cycle T+1 of a claim → mask cleared; after release, arbitration resumes with a 1-cycle latency and no spurious claim_o.
